mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one main memory port between icache and dcache miss/writeback traffic.
//  Sits between {icache, dcache} and the memory; the CPU never sees it.
//  Each requester sees a private memory port with busywait semantics.
//  One block transfer in flight at a time; owner is fixed until the transfer completes.
// PARAMETERS
//  ADDR_W   28   block address width (byte address >> 4)
//  BLOCK_W  128  data block width (4 x 32-bit words)
// PORTS
//  CLK           in   1        system clock, rising edge
//  RESET         in   1        asynchronous, active-high
//  I_READ        in   1        icache block read request
//  I_ADDRESS     in   ADDR_W   icache block address
//  I_READDATA    out  BLOCK_W  block returned to icache
//  I_BUSYWAIT    out  1        icache stall
//  D_READ        in   1        dcache block read request
//  D_WRITE       in   1        dcache block writeback request
//  D_ADDRESS     in   ADDR_W   dcache block address
//  D_WRITEDATA   in   BLOCK_W  dcache writeback block
//  D_READDATA    out  BLOCK_W  block returned to dcache
//  D_BUSYWAIT    out  1        dcache stall
//  M_READ        out  1        memory read strobe (registered)
//  M_WRITE       out  1        memory write strobe (registered)
//  M_ADDRESS     out  ADDR_W   memory block address (registered)
//  M_WRITEDATA   out  BLOCK_W  memory write block (registered)
//  M_READDATA    in   BLOCK_W  memory read block
//  M_BUSYWAIT    in   1        memory busy
// BEHAVIOUR
//  - FSM states: IDLE, ISSUE, WAIT, RELEASE; owner register OWN (0 = I, 1 = D).
//  - Reset (async, any state): state = IDLE; OWN = 0; M_READ/M_WRITE = 0;
//    M_ADDRESS/M_WRITEDATA = 0; I_READDATA/D_READDATA = 0.
//    An in-flight transfer is abandoned, not replayed.
//  - IDLE: if any request is pending, pick a winner, latch its address/data/op into the
//    M_* registers, set OWN, and go to ISSUE.
//    Default priority is fixed: dcache beats icache.
//  - ISSUE: exactly one cycle with the strobe high; M_BUSYWAIT is ignored in this cycle.
//    Next state is WAIT.
//  - WAIT: hold all M_* outputs. On the first edge with M_BUSYWAIT = 0:
//    latch M_READDATA into the owner's READDATA (reads only), drop M_READ/M_WRITE,
//    and go to RELEASE.
//  - RELEASE: one cycle. Owner's BUSYWAIT = 0 and its READDATA is valid.
//    Next state is IDLE. A new grant is earliest in the cycle after IDLE,
//    so there is a minimum of 1 idle memory cycle between transfers.
//  - X_BUSYWAIT (combinational) = (X request asserted) & ~(state == RELEASE & OWN == X).
//    It stays 1 while the non-owner waits, and is 0 when X is not requesting.
//  - Requesters must deassert their request the cycle after BUSYWAIT = 0.
//    A request still high in IDLE is treated as a new request.
//  - D_READ & D_WRITE both high: treated as a write; the read is ignored.
//  - Request dropped mid-transfer: the transfer still completes and the result is discarded.
//  - Latency, uncontended read with memory busy for N cycles after ISSUE:
//    request edge -> ISSUE +1 -> WAIT N -> RELEASE; BUSYWAIT low N+2 cycles after IDLE grant.
//  - READDATA registers hold their value until the next completed read for that port.
// CONFIGURATION
//  ARB_RR_EN undefined: fixed priority, dcache > icache.
//    The icache can starve under continuous dcache traffic.
//  ARB_RR_EN defined: round-robin. A last-served bit, set on entry to RELEASE (= OWN, reset 0),
//    gives the next contended grant to the other port. Uncontended grants are unchanged.
// TESTING
//  1 Reset: RESET=1 mid-WAIT with D_WRITE=1 -> M_WRITE=0 async; after RESET=0
//    and D_WRITE still high -> ISSUE replays the write.
//  2 I_READ, addr 0x0000010, memory busy 5 cycles, M_READDATA=0xDEADBEEF_...
//    -> I_READDATA = that value, I_BUSYWAIT low exactly 1 cycle, D_BUSYWAIT = 0 throughout.
//  3 I_READ and D_READ same cycle (fixed priority) -> D served first; I_BUSYWAIT held 1
//    until the second RELEASE; M_ADDRESS shows the D address, then the I address.
//  4 D_WRITE addr 0x0000ABC, data 0x1111..., then D_READ same addr
//    -> M_WRITE transfer, an IDLE gap of 1 cycle, then M_READ; the write payload
//    appears on M_WRITEDATA only while writing.
//  5 ARB_RR_EN: both ports request continuously for 4 transfers -> grant order D, I, D, I;
//    without the macro -> D, D, D, D.
//  6 D_READ & D_WRITE both high -> only M_WRITE asserted; D_READDATA unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the icache/dcache requesters, the arbiter and main memory.
// slave = arbiter view, master = environment (caches + memory) view.
interface mem_arbiter_if #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128
);
  logic               I_READ;
  logic [ADDR_W-1:0]  I_ADDRESS;
  logic [BLOCK_W-1:0] I_READDATA;
  logic               I_BUSYWAIT;

  logic               D_READ;
  logic               D_WRITE;
  logic [ADDR_W-1:0]  D_ADDRESS;
  logic [BLOCK_W-1:0] D_WRITEDATA;
  logic [BLOCK_W-1:0] D_READDATA;
  logic               D_BUSYWAIT;

  logic               M_READ;
  logic               M_WRITE;
  logic [ADDR_W-1:0]  M_ADDRESS;
  logic [BLOCK_W-1:0] M_WRITEDATA;
  logic [BLOCK_W-1:0] M_READDATA;
  logic               M_BUSYWAIT;

  modport slave (
    input  I_READ, I_ADDRESS,
    output I_READDATA, I_BUSYWAIT,
    input  D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
    output D_READDATA, D_BUSYWAIT,
    output M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA,
    input  M_READDATA, M_BUSYWAIT
  );

  modport master (
    output I_READ, I_ADDRESS,
    input  I_READDATA, I_BUSYWAIT,
    output D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
    input  D_READDATA, D_BUSYWAIT,
    input  M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA,
    output M_READDATA, M_BUSYWAIT
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one block-wide memory port between icache reads and dcache reads/writebacks.
// Build option ARB_RR_EN: round-robin on contended grants (default: dcache has fixed priority).
module mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128
) (
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic               own_q, own_d;          // 0 = icache, 1 = dcache
  logic               m_read_q, m_read_d;
  logic               m_write_q, m_write_d;
  logic [ADDR_W-1:0]  m_address_q, m_address_d;
  logic [BLOCK_W-1:0] m_writedata_q, m_writedata_d;
  logic [BLOCK_W-1:0] i_readdata_q, i_readdata_d;
  logic [BLOCK_W-1:0] d_readdata_q, d_readdata_d;
`ifdef ARB_RR_EN
  logic               last_q, last_d;
`endif

  logic i_req;
  logic d_req;
  logic grant_d;

  assign i_req = bus.I_READ;
  assign d_req = bus.D_READ | bus.D_WRITE;

`ifdef ARB_RR_EN
  // Contended grant goes to whichever port was not served last.
  assign grant_d = d_req & (~i_req | ~last_q);
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_d       = state_q;
    own_d         = own_q;
    m_read_d      = m_read_q;
    m_write_d     = m_write_q;
    m_address_d   = m_address_q;
    m_writedata_d = m_writedata_q;
    i_readdata_d  = i_readdata_q;
    d_readdata_d  = d_readdata_q;
`ifdef ARB_RR_EN
    last_d        = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_req | d_req) begin
          own_d   = grant_d;
          state_d = ST_ISSUE;
          if (grant_d) begin
            // Write wins when the dcache raises both read and write.
            m_write_d     = bus.D_WRITE;
            m_read_d      = ~bus.D_WRITE;
            m_address_d   = bus.D_ADDRESS;
            m_writedata_d = bus.D_WRITE ? bus.D_WRITEDATA : '0;
          end else begin
            m_write_d     = 1'b0;
            m_read_d      = 1'b1;
            m_address_d   = bus.I_ADDRESS;
            m_writedata_d = '0;
          end
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (!bus.M_BUSYWAIT) begin
          if (m_read_q) begin
            if (own_q) d_readdata_d = bus.M_READDATA;
            else       i_readdata_d = bus.M_READDATA;
          end
          m_read_d      = 1'b0;
          m_write_d     = 1'b0;
          m_writedata_d = '0;
          state_d       = ST_RELEASE;
`ifdef ARB_RR_EN
          last_d        = own_q;
`endif
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      own_q         <= 1'b0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
      i_readdata_q  <= '0;
      d_readdata_q  <= '0;
`ifdef ARB_RR_EN
      last_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      own_q         <= own_d;
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
      i_readdata_q  <= i_readdata_d;
      d_readdata_q  <= d_readdata_d;
`ifdef ARB_RR_EN
      last_q        <= last_d;
`endif
    end
  end

  // Only the owner sees busywait drop, and only during RELEASE.
  always_comb begin
    bus.I_BUSYWAIT  = i_req & ~((state_q == ST_RELEASE) & ~own_q);
    bus.D_BUSYWAIT  = d_req & ~((state_q == ST_RELEASE) & own_q);
    bus.I_READDATA  = i_readdata_q;
    bus.D_READDATA  = d_readdata_q;
    bus.M_READ      = m_read_q;
    bus.M_WRITE     = m_write_q;
    bus.M_ADDRESS   = m_address_q;
    bus.M_WRITEDATA = m_writedata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory transfers are queued at stimulus time
// and checked when the arbiter issues them; a small memory model drives M_BUSYWAIT/M_READDATA.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int BW = 128;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) arb_bus ();

  mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (arb_bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic           wr;
    logic [AW-1:0]  addr;
    logic [BW-1:0]  data;
  } xfer_t;

  xfer_t sb[$];

  function automatic logic [BW-1:0] pat(input logic [AW-1:0] a);
    return {4{4'hC, a}};
  endfunction

  logic [BW-1:0] mem [logic [AW-1:0]];
  int unsigned busy_n = 2;
  int unsigned cnt = 0;
  int idle_gap = 0;
  int last_gap = 0;
  int xfer_cnt = 0;
  logic prev_strobe = 1'b0;

  // Memory model: N busy WAIT cycles after ISSUE, then ready.
  always @(posedge CLK) begin
    logic strobe;
    xfer_t e;
    #1;
    strobe = arb_bus.M_READ | arb_bus.M_WRITE;
    if (strobe && !prev_strobe) begin
      last_gap = idle_gap;
      idle_gap = 0;
      xfer_cnt++;
      if (sb.size() == 0) begin
        check_val("sb_underflow", 128'(sb.size()), 128'd1);
      end else begin
        e = sb.pop_front();
        check_val("m_write", arb_bus.M_WRITE, e.wr);
        check_val("m_read", arb_bus.M_READ, !e.wr);
        check_val("m_address", arb_bus.M_ADDRESS, e.addr);
        check_val("m_writedata", arb_bus.M_WRITEDATA, e.wr ? e.data : '0);
      end
      if (arb_bus.M_WRITE) mem[arb_bus.M_ADDRESS] = arb_bus.M_WRITEDATA;
      else arb_bus.M_READDATA = mem.exists(arb_bus.M_ADDRESS) ? mem[arb_bus.M_ADDRESS]
                                                             : pat(arb_bus.M_ADDRESS);
      arb_bus.M_BUSYWAIT = 1'b1;
      cnt = busy_n;
    end else if (strobe) begin
      if (cnt == 0) arb_bus.M_BUSYWAIT = 1'b0;
      else begin
        arb_bus.M_BUSYWAIT = 1'b1;
        cnt--;
      end
    end else begin
      arb_bus.M_BUSYWAIT = 1'b0;
      idle_gap++;
      if (prev_strobe) check_val("m_wdata_clear", arb_bus.M_WRITEDATA, '0);
    end
    prev_strobe = strobe;
  end

  logic d_bw_mon = 1'b0;
  logic d_bw_seen = 1'b0;
  always @(negedge CLK) if (d_bw_mon && arb_bus.D_BUSYWAIT) d_bw_seen = 1'b1;

  task automatic d_request(input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [BW-1:0] wd, input logic [BW-1:0] exp_rd,
                           input logic chk_rd, output int waited);
    logic done;
    arb_bus.D_READ = rd;
    arb_bus.D_WRITE = wr;
    arb_bus.D_ADDRESS = a;
    arb_bus.D_WRITEDATA = wd;
    waited = 0;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (!arb_bus.D_BUSYWAIT) begin
        done = 1'b1;
        break;
      end
      waited++;
    end
    check_val("d_done", done, 1'b1);
    if (done && chk_rd) check_val("d_readdata", arb_bus.D_READDATA, exp_rd);
    @(posedge CLK);
    #1;
    arb_bus.D_READ = 1'b0;
    arb_bus.D_WRITE = 1'b0;
  endtask

  task automatic i_request(input logic [AW-1:0] a, input logic [BW-1:0] exp_rd,
                           output int waited);
    logic done;
    arb_bus.I_READ = 1'b1;
    arb_bus.I_ADDRESS = a;
    waited = 0;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (!arb_bus.I_BUSYWAIT) begin
        done = 1'b1;
        break;
      end
      waited++;
    end
    check_val("i_done", done, 1'b1);
    if (done) check_val("i_readdata", arb_bus.I_READDATA, exp_rd);
    @(posedge CLK);
    #1;
    arb_bus.I_READ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wi, wd, base;
    logic done;
    logic [BW-1:0] d11, d22, d33, dbeef;
    d11   = {4{32'h11111111}};
    d22   = {4{32'h22222222}};
    d33   = {4{32'h33333333}};
    dbeef = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    RESET = 1'b1;
    arb_bus.I_READ = 1'b0;  arb_bus.I_ADDRESS = '0;
    arb_bus.D_READ = 1'b0;  arb_bus.D_WRITE = 1'b0;
    arb_bus.D_ADDRESS = '0; arb_bus.D_WRITEDATA = '0;
    arb_bus.M_READDATA = '0; arb_bus.M_BUSYWAIT = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_val("rst_m_read", arb_bus.M_READ, 1'b0);
    check_val("rst_m_write", arb_bus.M_WRITE, 1'b0);
    check_val("rst_m_address", arb_bus.M_ADDRESS, '0);
    check_val("rst_m_writedata", arb_bus.M_WRITEDATA, '0);
    check_val("rst_i_readdata", arb_bus.I_READDATA, '0);
    check_val("rst_d_readdata", arb_bus.D_READDATA, '0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Continuous contention for four transfers.
    busy_n = 0;
`ifdef ARB_RR_EN
    sb.push_back('{1'b0, 28'h40, '0}); sb.push_back('{1'b0, 28'h50, '0});
    sb.push_back('{1'b0, 28'h40, '0}); sb.push_back('{1'b0, 28'h50, '0});
`else
    for (int k = 0; k < 4; k++) sb.push_back('{1'b0, 28'h40, '0});
`endif
    base = xfer_cnt;
    arb_bus.I_READ = 1'b1; arb_bus.I_ADDRESS = 28'h50;
    arb_bus.D_READ = 1'b1; arb_bus.D_ADDRESS = 28'h40;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (xfer_cnt >= base + 4 && !arb_bus.M_READ && !arb_bus.M_WRITE) begin
        done = 1'b1;
        break;
      end
    end
    check_val("contend_done", done, 1'b1);
    @(posedge CLK);
    #1;
    arb_bus.I_READ = 1'b0;
    arb_bus.D_READ = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_val("contend_count", 128'(xfer_cnt - base), 128'd4);

    // Uncontended icache read, memory busy 5 cycles.
    busy_n = 5;
    mem[28'h10] = dbeef;
    sb.push_back('{1'b0, 28'h10, '0});
    d_bw_seen = 1'b0;
    d_bw_mon = 1'b1;
    i_request(28'h10, dbeef, wi);
    d_bw_mon = 1'b0;
    check_val("i_latency", 128'(wi), 128'(busy_n + 3));
    check_val("d_bw_quiet", d_bw_seen, 1'b0);
    @(negedge CLK);
    check_val("i_bw_after", arb_bus.I_BUSYWAIT, 1'b0);
    @(posedge CLK);
    #1;

    // Simultaneous icache and dcache reads: dcache first.
    busy_n = 1;
    sb.push_back('{1'b0, 28'h30, '0});
    sb.push_back('{1'b0, 28'h20, '0});
    fork
      i_request(28'h20, pat(28'h20), wi);
      d_request(1'b1, 1'b0, 28'h30, '0, pat(28'h30), 1'b1, wd);
    join
    check_val("d_first_wait", 128'(wd), 128'd4);
    check_val("i_held_wait", 128'(wi), 128'd9);
    repeat (2) @(posedge CLK);
    #1;

    // Writeback then read of the same block, back to back.
    busy_n = 2;
    sb.push_back('{1'b1, 28'hABC, d11});
    sb.push_back('{1'b0, 28'hABC, '0});
    d_request(1'b0, 1'b1, 28'hABC, d11, '0, 1'b0, wd);
    d_request(1'b1, 1'b0, 28'hABC, '0, d11, 1'b1, wd);
    // Strobes low for RELEASE plus one IDLE cycle between the two transfers.
    check_val("idle_gap", 128'(last_gap), 128'd2);
    repeat (2) @(posedge CLK);
    #1;

    // Read and write together: write only, read data untouched.
    sb.push_back('{1'b1, 28'hABD, d22});
    d_request(1'b1, 1'b1, 28'hABD, d22, '0, 1'b0, wd);
    check_val("rw_d_readdata", arb_bus.D_READDATA, d11);
    repeat (2) @(posedge CLK);
    #1;

    // Reset mid-WAIT abandons the write; a still-high request replays it.
    busy_n = 10;
    sb.push_back('{1'b1, 28'h77, d33});
    sb.push_back('{1'b1, 28'h77, d33});
    arb_bus.D_WRITE = 1'b1; arb_bus.D_ADDRESS = 28'h77; arb_bus.D_WRITEDATA = d33;
    done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (arb_bus.M_WRITE) begin
        done = 1'b1;
        break;
      end
    end
    check_val("rst_wr_started", done, 1'b1);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    #1;
    check_val("async_m_write", arb_bus.M_WRITE, 1'b0);
    check_val("async_m_address", arb_bus.M_ADDRESS, '0);
    check_val("async_d_readdata", arb_bus.D_READDATA, '0);
    check_val("async_i_readdata", arb_bus.I_READDATA, '0);
    @(negedge CLK);
    RESET = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (!arb_bus.D_BUSYWAIT) begin
        done = 1'b1;
        break;
      end
    end
    check_val("replay_done", done, 1'b1);
    @(posedge CLK);
    #1;
    arb_bus.D_WRITE = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_val("replay_mem", mem.exists(28'h77) ? mem[28'h77] : '0, d33);
    check_val("sb_drained", 128'(sb.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
